// File: rtl/hack_program_memory.sv
// Loadable Hack instruction store with run control: load port, registered fetch,
// CPU reset/enable generation, halt, single-step and a single-address breakpoint.
module hack_program_memory #(
  parameter int unsigned             ADDR_WIDTH = 12,
  parameter int unsigned             DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0]   NOP_INST   = '0,
  parameter bit                      AUTO_RUN   = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load_valid,
  output logic                  o_load_ready,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  input  logic                  i_load_last,
  input  logic                  i_run_req,
  input  logic                  i_halt_req,
  input  logic                  i_step_req,
  input  logic                  i_bp_en,
  input  logic [15:0]           i_bp_addr,
  input  logic [15:0]           i_pc,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic                  o_cpu_reset,
  output logic                  o_cpu_en,
  output logic [1:0]            o_state,
  output logic [31:0]           o_exec_count
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoading = 2'd1,
    StRunning = 2'd2,
    StHalted  = 2'd3
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  state_e                w_done_state;
  logic                  r_bp_skip;
  logic [DATA_WIDTH-1:0] r_inst;
  logic [31:0]           r_exec_count;
  logic [DATA_WIDTH-1:0] r_store [Depth];

  logic w_loadable;
  logic w_load_fire;
  logic w_bp_hit;
  logic w_pc_in_range;
  logic w_cpu_en;

  assign w_loadable    = (r_state == StIdle) || (r_state == StLoading);
  assign o_load_ready  = w_loadable && !i_reset;
  assign o_cpu_reset   = i_reset || w_loadable;
  assign w_load_fire   = i_load_valid && o_load_ready;
  assign w_done_state  = AUTO_RUN ? StRunning : StHalted;
  assign w_pc_in_range = (i_pc >> ADDR_WIDTH) == 16'd0;
  // Breakpoint is masked for the first cycle after resuming so execution can leave bp_addr.
  assign w_bp_hit      = i_bp_en && (i_pc == i_bp_addr) && !r_bp_skip;

  always_comb begin
    w_state_next = r_state;
    w_cpu_en     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_load_fire) begin
          w_state_next = i_load_last ? w_done_state : StLoading;
        end else if (i_run_req) begin
          w_state_next = StRunning;
        end
      end
      StLoading: begin
        if (w_load_fire && i_load_last) w_state_next = w_done_state;
      end
      StRunning: begin
        w_cpu_en = !w_bp_hit;
        if (i_halt_req || w_bp_hit) w_state_next = StHalted;
      end
      StHalted: begin
        if (!i_halt_req) begin
          if (i_run_req) begin
            w_state_next = StRunning;
          end else begin
            w_cpu_en = i_step_req;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_bp_skip    <= 1'b0;
      r_inst       <= NOP_INST;
      r_exec_count <= 32'd0;
    end else begin
      r_state   <= w_state_next;
      r_bp_skip <= (r_state == StHalted) && (w_state_next == StRunning);
      if (w_cpu_en) begin
        r_exec_count <= r_exec_count + 32'd1;
        r_inst       <= w_pc_in_range ? r_store[i_pc[ADDR_WIDTH-1:0]] : NOP_INST;
      end
    end
  end

  // Contents deliberately survive reset so a retained program can be rerun.
  always_ff @(posedge i_clk) begin
    if (w_load_fire) r_store[i_load_addr] <= i_load_data;
  end

  assign o_cpu_en     = w_cpu_en && !i_reset;
  assign o_inst       = r_inst;
  assign o_state      = r_state;
  assign o_exec_count = r_exec_count;

endmodule

// File: tb/tb_hack_program_memory.sv
// Directed bench for hack_program_memory: load, run, breakpoint, step, halt/run priority,
// out-of-range fetch, blocked loads while running and reset during a load.
module tb_hack_program_memory;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] Nop = 16'h0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic          load_ready;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          run_req;
  logic          halt_req;
  logic          step_req;
  logic          bp_en;
  logic [15:0]   bp_addr;
  logic [15:0]   pc;
  logic [DW-1:0] inst;
  logic          cpu_reset;
  logic          cpu_en;
  logic [1:0]    state;
  logic [31:0]   exec_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hack_program_memory #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NOP_INST  (Nop),
    .AUTO_RUN  (1'b1)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_load_valid(load_valid),
    .o_load_ready(load_ready),
    .i_load_addr (load_addr),
    .i_load_data (load_data),
    .i_load_last (load_last),
    .i_run_req   (run_req),
    .i_halt_req  (halt_req),
    .i_step_req  (step_req),
    .i_bp_en     (bp_en),
    .i_bp_addr   (bp_addr),
    .i_pc        (pc),
    .o_inst      (inst),
    .o_cpu_reset (cpu_reset),
    .o_cpu_en    (cpu_en),
    .o_state     (state),
    .o_exec_count(exec_count)
  );

  typedef struct {
    logic [15:0] pc;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic        run;
    logic        halt;
    logic        step;
    logic        exp_en;
    logic [15:0] exp_inst;
    logic [1:0]  exp_state;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t        vecs[21];
  logic [15:0] prog[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    prog = '{16'h0002, 16'hEC10, 16'h0003, 16'hE090, 16'h0000, 16'hE308, 16'h0006, 16'hEA87};
    //        pc     bp  bpa   run  hlt  stp  en   inst      st    cnt
    vecs[0]  = '{16'd0, 1, 16'd5, 0, 0, 0, 1, 16'h0002, 2'd2, 32'd1};
    vecs[1]  = '{16'd1, 1, 16'd5, 0, 0, 0, 1, 16'hEC10, 2'd2, 32'd2};
    vecs[2]  = '{16'd2, 1, 16'd5, 0, 0, 0, 1, 16'h0003, 2'd2, 32'd3};
    vecs[3]  = '{16'd3, 1, 16'd5, 0, 0, 0, 1, 16'hE090, 2'd2, 32'd4};
    vecs[4]  = '{16'd4, 1, 16'd5, 0, 0, 0, 1, 16'h0000, 2'd2, 32'd5};
    vecs[5]  = '{16'd5, 1, 16'd5, 0, 0, 0, 0, 16'h0000, 2'd3, 32'd5};
    vecs[6]  = '{16'd5, 1, 16'd5, 0, 0, 0, 0, 16'h0000, 2'd3, 32'd5};
    vecs[7]  = '{16'd5, 1, 16'd5, 0, 0, 1, 1, 16'hE308, 2'd3, 32'd6};
    vecs[8]  = '{16'd6, 1, 16'd5, 0, 0, 0, 0, 16'hE308, 2'd3, 32'd6};
    vecs[9]  = '{16'd6, 1, 16'd5, 0, 0, 1, 1, 16'h0006, 2'd3, 32'd7};
    vecs[10] = '{16'd7, 1, 16'd5, 0, 0, 0, 0, 16'h0006, 2'd3, 32'd7};
    vecs[11] = '{16'd7, 1, 16'd5, 0, 0, 1, 1, 16'hEA87, 2'd3, 32'd8};
    vecs[12] = '{16'd5, 1, 16'd5, 1, 0, 0, 0, 16'hEA87, 2'd2, 32'd8};
    vecs[13] = '{16'd5, 1, 16'd5, 0, 0, 0, 1, 16'hE308, 2'd2, 32'd9};
    vecs[14] = '{16'd6, 1, 16'd5, 0, 0, 0, 1, 16'h0006, 2'd2, 32'd10};
    vecs[15] = '{16'h2000, 1, 16'd5, 0, 0, 0, 1, 16'h0000, 2'd2, 32'd11};
    vecs[16] = '{16'd7, 1, 16'd5, 1, 1, 0, 1, 16'hEA87, 2'd3, 32'd12};
    vecs[17] = '{16'd7, 1, 16'd5, 0, 1, 1, 0, 16'hEA87, 2'd3, 32'd12};
    vecs[18] = '{16'd5, 1, 16'd5, 1, 0, 1, 0, 16'hEA87, 2'd2, 32'd12};
    vecs[19] = '{16'd5, 1, 16'd5, 0, 0, 0, 1, 16'hE308, 2'd2, 32'd13};
    vecs[20] = '{16'd5, 1, 16'd5, 0, 0, 0, 0, 16'hE308, 2'd3, 32'd13};

    reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; bp_en = 1'b0; bp_addr = '0; pc = '0;

    // Reset state
    tick;
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    tick;
    reset = 1'b0;
    #1;
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_inst", 32'(inst), 32'(Nop));
    chk("idle_count", exec_count, 32'd0);
    chk("idle_load_ready", 32'(load_ready), 32'd1);

    // Load the 8-word program, last on word 7
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1; load_addr = AW'(i); load_data = prog[i]; load_last = (i == 7);
      tick;
      if (i == 0) chk("load_state_first", 32'(state), 32'd1);
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("load_done_state", 32'(state), 32'd2);
    chk("load_done_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("load_done_count", exec_count, 32'd0);

    // Run / breakpoint / step / priority vectors
    for (int i = 0; i < 21; i++) begin
      pc = vecs[i].pc; bp_en = vecs[i].bp_en; bp_addr = vecs[i].bp_addr;
      run_req = vecs[i].run; halt_req = vecs[i].halt; step_req = vecs[i].step;
      #1;
      chk($sformatf("v%0d_cpu_en", i), 32'(cpu_en), 32'(vecs[i].exp_en));
      tick;
      chk($sformatf("v%0d_inst", i), 32'(inst), 32'(vecs[i].exp_inst));
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      chk($sformatf("v%0d_count", i), exec_count, vecs[i].exp_cnt);
    end
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; bp_en = 1'b0;

    // Load attempt while RUNNING must be refused and leave the store intact
    pc = 16'd0; run_req = 1'b1;
    tick;
    run_req = 1'b0;
    chk("resume_state", 32'(state), 32'd2);
    load_valid = 1'b1; load_addr = '0; load_data = 16'hFFFF; load_last = 1'b1;
    #1;
    chk("run_load_ready", 32'(load_ready), 32'd0);
    tick;
    load_valid = 1'b0; load_last = 1'b0;
    chk("run_load_state", 32'(state), 32'd2);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_inst", 32'(inst), 32'(Nop));
    chk("rst2_count", exec_count, 32'd0);
    run_req = 1'b1;
    tick;
    run_req = 1'b0;
    chk("rerun_state", 32'(state), 32'd2);
    chk("rerun_cpu_reset", 32'(cpu_reset), 32'd0);
    pc = 16'd0;
    tick;
    chk("rerun_inst0", 32'(inst), 32'h0002);
    pc = 16'd1;
    tick;
    chk("rerun_inst1", 32'(inst), 32'hEC10);

    // Reset after 10 of 20 words; retained words must run
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1; load_addr = AW'(i); load_data = 16'hA000 + 16'(i); load_last = 1'b0;
      run_req = (i == 5);
      tick;
      chk($sformatf("partial_state%0d", i), 32'(state), 32'd1);
    end
    run_req = 1'b0;
    load_addr = AW'(10); load_data = 16'hA00A;
    reset = 1'b1;
    #1;
    chk("midload_rst_ready", 32'(load_ready), 32'd0);
    tick;
    reset = 1'b0; load_valid = 1'b0;
    #1;
    chk("midload_state", 32'(state), 32'd0);
    chk("midload_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midload_inst", 32'(inst), 32'(Nop));
    run_req = 1'b1;
    tick;
    run_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pc = 16'(i);
      tick;
      chk($sformatf("retained_inst%0d", i), 32'(inst), 32'(16'hA000 + 16'(i)));
    end
    chk("retained_count", exec_count, 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hack_program_memory.md
Name: hack_program_memory

Overview:
Parametrised, loadable instruction memory with run control for the Hack computer. It replaces the fixed case-table instruction ROM with a writable instruction store, filled through a valid/ready load port. It provides the CPU's registered instruction fetch, drives the CPU reset and clock-enable, and adds halt, single-step and a breakpoint. It sits between the CPU (pc in, inst out) and the host/debug side.

Parameters:
ADDR_WIDTH, 12, instruction store depth is 2**ADDR_WIDTH words (4096).
DATA_WIDTH, 16, instruction word width.
NOP_INST, 16'h0000, word returned for out-of-range pc and after reset (@0).
AUTO_RUN, 1, 1: load_last moves to RUNNING; 0: moves to HALTED.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
load_valid  in  1  load word present
load_ready  out  1  store accepts load words
load_addr  in  ADDR_WIDTH  write address
load_data  in  DATA_WIDTH  instruction word
load_last  in  1  final word of the program
run_req  in  1  start or resume (1-cycle pulse)
halt_req  in  1  halt request (pulse)
step_req  in  1  single-step request (pulse)
bp_en  in  1  breakpoint enable
bp_addr  in  16  breakpoint pc
pc  in  16  CPU program counter
inst  out  DATA_WIDTH  registered instruction to CPU
cpu_reset  out  1  CPU reset
cpu_en  out  1  CPU clock enable
state  out  2  0 IDLE, 1 LOADING, 2 RUNNING, 3 HALTED
exec_count  out  32  count of enabled CPU cycles

Behaviour:
- Reset values: state IDLE; inst = NOP_INST; cpu_reset = 1; cpu_en = 0; load_ready = 0 in the reset cycle; exec_count = 0. Store contents are not cleared.
- load_ready is 1 in IDLE or LOADING, otherwise 0. A write occurs on clk when load_valid && load_ready.
- cpu_reset is 1 in IDLE and LOADING, otherwise 0.
- IDLE:
  - An accepted word without load_last goes to LOADING.
  - An accepted word with load_last goes to RUNNING if AUTO_RUN, else HALTED.
  - run_req goes to RUNNING and runs the retained contents.
- LOADING:
  - Accepts words in any address order; the last write to an address wins.
  - load_last goes to RUNNING or HALTED per AUTO_RUN.
  - run_req, halt_req and step_req are ignored.
- RUNNING:
  - cpu_en = !(bp_en && pc == bp_addr), combinational.
  - When cpu_en = 1: inst <= store[pc] if pc < 2**ADDR_WIDTH, else NOP_INST. Fetch latency is 1 cycle; exec_count increments by 1 and wraps at 2**32.
  - A breakpoint hit (cpu_en = 0) goes to HALTED next cycle. No fetch occurs, inst holds and exec_count holds.
  - halt_req goes to HALTED. The fetch in the halt_req cycle still occurs.
- HALTED:
  - cpu_en = step_req, combinational. A step performs exactly one fetch and one increment, then stays HALTED.
  - run_req goes to RUNNING. The first RUNNING cycle ignores the breakpoint so execution can resume past bp_addr.
  - inst holds whenever cpu_en = 0.
- Priorities:
  - reset beats everything.
  - halt_req beats run_req and step_req.
  - run_req beats step_req in HALTED.
  - load_valid outside IDLE/LOADING is ignored and nothing is written.
- Reset mid-load returns to IDLE; words already written stay in the store.
- A write and a fetch to the same address in the same cycle cannot occur, because loading and running are exclusive states.
- The store is inferred as a synchronous single-write, single-read block RAM with no reset on its contents.

Test Plan:
- Load @2, D=A, @3, D=D+A, @0, M=D, @6, 0;JMP at addresses 0-7, last on word 7, AUTO_RUN=1 -> state goes 0→1→2; cpu_reset falls; with pc=0 one cycle later inst = 16'h0002; exec_count counts from 1.
- RUNNING with bp_en=1, bp_addr=5, pc reaches 5 -> cpu_en=0 that cycle; state=3 next cycle; inst keeps the word for pc 4; exec_count frozen.
- HALTED, step_req pulsed 3 times with gaps -> exactly 3 cycles with cpu_en=1; exec_count +3; state stays 3; run_req with pc=5 still at bp_addr -> resumes without re-halting.
- pc=16'h2000 with ADDR_WIDTH=12 -> inst = NOP_INST.
- halt_req and run_req in the same cycle while RUNNING -> HALTED; load_valid=1 while RUNNING -> load_ready=0 and the store is unchanged (verified by reload-free run from IDLE after reset).
- reset asserted after 10 of 20 words loaded -> state=0, cpu_reset=1, inst=NOP_INST; run_req then executes the 10 retained words.
